hazard_scoreboard: RTL

Parametrised hazard and forwarding unit for the in-order MIPS pipeline. It keeps a registered shadow of the post-decode stages: one slot per stage holding the destination register and its remaining Tnew, shifted every cycle. Against that shadow it resolves D-stage stalls by Tuse/Tnew comparison, along with forwarding selects for the D, E and M readers. An optional multiply/divide busy counter adds the MD-unit stall.

---
 rtl/hazard_scoreboard.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard and forwarding unit for the in-order MIPS pipeline.
//   A registered shadow of the post-decode stages (slot 1 = E, slot 2 = M,
//   slot 3 = W, ...) holds {valid, dest reg, remaining Tnew} per stage and
//   shifts every cycle. D-stage stalls come from Tuse/Tnew comparison against
//   that shadow; forwarding selects are produced for the D, E and M readers.
//
//   Optional feature macro: HAZ_MD_EN
//     defined   : multiply/divide busy counter, md_busy output, MD stall term
//     undefined : md_busy tied low, use_md_d / md_start / md_div ignored
//
//   Forward encoding on every fwd_* output: 0 = register file / pipeline
//   register, k = result currently held in slot k.
//   Parameter constraints: NSTAGE >= 3 and NSTAGE <= 2**FW - 1.

module hazard_scoreboard #(
    parameter int NSTAGE  = 3,
    parameter int TW      = 3,
    parameter int FW      = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          iss_we,
    input  logic [4:0]    iss_a3,
    input  logic [TW-1:0] iss_tnew,
    input  logic [4:0]    rs_d,
    input  logic [4:0]    rt_d,
    input  logic [TW-1:0] tuse_rs_d,
    input  logic [TW-1:0] tuse_rt_d,
    input  logic [4:0]    rs_e,
    input  logic [4:0]    rt_e,
    input  logic [4:0]    rt_m,
    input  logic          use_md_d,
    input  logic          md_start,
    input  logic          md_div,
    output logic          stall,
    output logic [FW-1:0] fwd_rs_d,
    output logic [FW-1:0] fwd_rt_d,
    output logic [FW-1:0] fwd_rs_e,
    output logic [FW-1:0] fwd_rt_e,
    output logic [FW-1:0] fwd_rt_m,
    output logic          md_busy
);

    // Result of searching the shadow for one source register.
    typedef struct packed {
        logic          hit;
        logic [FW-1:0] idx;
        logic [TW-1:0] tnew;
    } match_t;

    // Query start slots: a reader in stage q only looks at slots q+1 and up.
    localparam int FIRST_D = 1;
    localparam int FIRST_E = 2;
    localparam int FIRST_M = 3;

    // Shadow slots, index 1 is the youngest (E stage).
    logic [NSTAGE:1]             v_q,    v_d;
    logic [NSTAGE:1][4:0]        a3_q,   a3_d;
    logic [NSTAGE:1][TW-1:0]     tnew_q, tnew_d;

    match_t m_rs_d, m_rt_d, m_rs_e, m_rt_e, m_rt_m;
    logic   raw_stall_rs, raw_stall_rt;
    logic   md_stall;

    // Youngest producer of src among slots first..NSTAGE. The loop walks from
    // the oldest slot downwards so the last hit (lowest index) wins. A slot
    // writing $0 is never a producer, which also makes reads of $0 miss.
    function automatic match_t find_producer(
        input logic [4:0]              src,
        input int                      first,
        input logic [NSTAGE:1]         v,
        input logic [NSTAGE:1][4:0]    a3,
        input logic [NSTAGE:1][TW-1:0] tn
    );
        match_t m;
        m = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (k >= first && v[k] && a3[k] != 5'd0 && a3[k] == src) begin
                m.hit  = 1'b1;
                m.idx  = FW'(k);
                m.tnew = tn[k];
            end
        end
        return m;
    endfunction

    // A winning producer is forwarded only once its value exists (tnew == 0).
    // For E and M readers a pending winner is a protocol violation and
    // deliberately selects the pipeline register.
    function automatic logic [FW-1:0] fwd_select(input match_t m);
        return (m.hit && m.tnew == '0) ? m.idx : '0;
    endfunction

    // Search the shadow for every reader of the current cycle.
    always_comb begin
        m_rs_d = find_producer(rs_d, FIRST_D, v_q, a3_q, tnew_q);
        m_rt_d = find_producer(rt_d, FIRST_D, v_q, a3_q, tnew_q);
        m_rs_e = find_producer(rs_e, FIRST_E, v_q, a3_q, tnew_q);
        m_rt_e = find_producer(rt_e, FIRST_E, v_q, a3_q, tnew_q);
        m_rt_m = find_producer(rt_m, FIRST_M, v_q, a3_q, tnew_q);
    end

    // D-stage stall: a producer that needs more cycles than the reader can
    // wait. An all-ones Tuse ("not read") can never be exceeded unsigned.
    always_comb begin
        raw_stall_rs = m_rs_d.hit && (m_rs_d.tnew > tuse_rs_d);
        raw_stall_rt = m_rt_d.hit && (m_rt_d.tnew > tuse_rt_d);
        stall        = raw_stall_rs || raw_stall_rt || md_stall;
    end

    // Forwarding selects for the D, E and M readers.
    always_comb begin
        fwd_rs_d = fwd_select(m_rs_d);
        fwd_rt_d = fwd_select(m_rt_d);
        fwd_rs_e = fwd_select(m_rs_e);
        fwd_rt_e = fwd_select(m_rt_e);
        fwd_rt_m = fwd_select(m_rt_m);
    end

    // Next shadow: slot 1 takes the D instruction unless it is being held
    // (then a bubble enters E); every other slot takes its younger
    // neighbour with Tnew counted down, saturating at zero.
    always_comb begin
        v_d    = '0;
        a3_d   = '0;
        tnew_d = '0;
        if (!stall) begin
            v_d[1]    = iss_we;
            a3_d[1]   = iss_a3;
            tnew_d[1] = iss_tnew;
        end
        for (int k = 2; k <= NSTAGE; k++) begin
            v_d[k]    = v_q[k-1];
            a3_d[k]   = a3_q[k-1];
            tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
        end
    end

    // Shadow register: shifts every cycle, stall or not; reset empties it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v_q    <= '0;
            a3_q   <= '0;
            tnew_q <= '0;
        end else begin
            v_q    <= v_d;
            a3_q   <= a3_d;
            tnew_q <= tnew_d;
        end
    end

`ifdef HAZ_MD_EN
    localparam int CW = $clog2(DIV_LAT + 1);

    logic [CW-1:0] md_cnt_q, md_cnt_d;

    // Busy countdown: a start (even while busy) reloads with the operation
    // latency, otherwise count down to idle.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start) begin
            md_cnt_d = md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    // Busy counter register; reset abandons any running operation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    // The start cycle itself already counts as busy.
    always_comb begin
        md_busy  = md_start || (md_cnt_q != '0);
        md_stall = use_md_d && md_busy;
    end
`else
    logic unused_md_inputs;

    // No MD unit tracking: busy and the MD stall term are constant low.
    always_comb begin
        md_busy          = 1'b0;
        md_stall         = 1'b0;
        unused_md_inputs = ^{use_md_d, md_start, md_div};
    end
`endif

endmodule
